// File: rtl/lut_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_loader_pkg
// Purpose  : Shared definitions for the LUT loader: loader FSM state encoding
//            and the default LUT geometry also used by the LUT RAM wrappers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lut_loader_pkg;

  // Default LUT geometry: 1024 words of 8 bits.
  localparam int LUT_ADDR_WIDTH = 10;
  localparam int LUT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lut_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_loader_if
// Purpose  : Bundles the loader control, byte-stream and LUT write-port
//            signals.
// Ports    : slave  - the loader: consumes start/abort/stream, drives the
//                     LUT write port and status.
//            master - the host side: drives start/abort/stream, observes
//                     s_ready, the write port and status.
// Revision : 1.0 - initial release
// ============================================================================
interface lut_loader_if
  import lut_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
);

  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, abort, s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport master (
    output start, abort, s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : lut_loader
// Purpose  : Loads a complete LUT image (2**ADDR_WIDTH words) from a
//            valid/ready byte stream into a RAM-based LUT write port using
//            sequential addresses, then consumes one trailing checksum word
//            (sum of all image words mod 2**DATA_WIDTH) and reports status.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - lut_loader_if.slave: start/abort control, s_data/
//                    s_valid/s_ready stream, wr_en/wr_addr/wr_data LUT
//                    write port (1-cycle registered latency), busy/done/err
// Revision : 1.0 - initial release
// ============================================================================
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  lut_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

  state_e                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] sum_q,     sum_d;
  logic                  err_q,     err_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic w_ready;
  logic w_hs;

  // The stream is open in LOAD (image words) and CHECK (trailer word).
  assign w_ready = (state_q == LOAD) || (state_q == CHECK);
  assign w_hs    = bus.s_valid && w_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        // abort outranks a coincident start
        if (bus.start && !bus.abort) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        if (bus.abort) begin
          // a word accepted in the abort cycle is dropped
          state_d = IDLE;
        end else if (w_hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = bus.s_data;
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
          sum_d     = sum_q + bus.s_data;
          if (cnt_q == c_last_addr) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (w_hs) begin
          // trailer word: compared only, never written
          err_d   = (bus.s_data != sum_q);
          state_d = FIN;
        end
      end

      FIN: begin
        // start here is ignored; a new load needs start in IDLE
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.s_ready = w_ready;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FIN);
  assign bus.err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_loader
// Purpose  : Self-checking bench for lut_loader. Image words are pushed to a
//            scoreboard when driven and popped against the LUT write port;
//            a model LUT memory is filled from the write port and read back
//            against the image after each load.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_loader;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  // pattern: 0 = addr[7:0], 1 = all 0xFF, 2 = random
  typedef struct {
    int            pattern;
    bit            trailer_is_sum;
    logic [DW-1:0] trailer;
    int            duty;
    bit            exp_err;
  } vec_t;

  logic clk;
  logic rst_n;

  lut_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks;
  int            errors;
  int            wr_count;
  int            done_count;
  int            wr_base;
  int            done_base;
  bit            stalled;
  wr_exp_t       sb_q[$];
  logic [DW-1:0] img     [N];
  logic [DW-1:0] lut_mem [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-port scoreboard and model LUT memory.
  task automatic monitor();
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wr_en) begin
        wr_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_write_addr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
        lut_mem[bus.wr_addr] = bus.wr_data;
      end
      if (bus.done) done_count++;
    end
  endtask

  function automatic logic [DW-1:0] pat_word(input int pattern, input int i);
    logic [31:0] v;
    v = 32'(i);
    case (pattern)
      0:       return v[7:0];
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Entered and left at a negedge; holds s_valid until the DUT accepts.
  task automatic send_word(input logic [DW-1:0] d, input bit is_image,
                           input logic [AW-1:0] a, input int duty);
    int waited;
    waited = 0;
    while (duty < 100 && int'($urandom_range(99)) >= duty) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && !stalled) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        stalled = 1'b1;
        check("s_ready_timeout", 32'(waited), 32'd0);
      end
    end
    if (is_image && !stalled) sb_q.push_back('{addr: a, data: d});
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic start_load();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("ready_after_start", 32'(bus.s_ready), 32'd1);
    check("err_cleared_by_start", 32'(bus.err), 32'd0);
    wr_base   = wr_count;
    done_base = done_count;
  endtask

  task automatic finish_load(input logic [DW-1:0] trailer, input bit exp_err);
    int mism;
    send_word(trailer, 1'b0, '0, 100);
    // FIN cycle: done visible one cycle after the trailer handshake
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_in_fin", 32'(bus.busy), 32'd1);
    check("ready_in_fin", 32'(bus.s_ready), 32'd0);
    check("err_at_done", 32'(bus.err), 32'(exp_err));
    bus.start = 1'b1;                   // start coincident with done is ignored
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after_fin", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_after_fin_start", 32'(bus.busy), 32'd0);
    check("err_sticky", 32'(bus.err), 32'(exp_err));
    check("write_count", 32'(wr_count - wr_base), 32'(N));
    check("done_count", 32'(done_count - done_base), 32'd1);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < N; i++) if (lut_mem[i] !== img[i]) mism++;
    check("readback_mismatches", 32'(mism), 32'd0);
  endtask

  task automatic full_load(input vec_t v);
    logic [DW-1:0] sum;
    logic [DW-1:0] trl;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      img[i] = pat_word(v.pattern, i);
      sum    = sum + img[i];
    end
    trl = v.trailer_is_sum ? sum : v.trailer;
    start_load();
    for (int i = 0; i < N; i++) send_word(img[i], 1'b1, AW'(i), v.duty);
    finish_load(trl, v.exp_err);
  endtask

  vec_t vecs[5];

  initial begin
    checks     = 0;
    errors     = 0;
    wr_count   = 0;
    done_count = 0;
    wr_base    = 0;
    done_base  = 0;
    stalled    = 1'b0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;

    // sum(addr[7:0]) over 1024 words = 4*32640 = 0 mod 256;
    // 1024*0xFF = 0 mod 256
    vecs[0] = '{pattern: 0, trailer_is_sum: 1'b0, trailer: 8'h00, duty: 100, exp_err: 1'b0};
    vecs[1] = '{pattern: 1, trailer_is_sum: 1'b0, trailer: 8'h01, duty: 100, exp_err: 1'b1};
    vecs[2] = '{pattern: 0, trailer_is_sum: 1'b0, trailer: 8'h00, duty: 50,  exp_err: 1'b0};
    vecs[3] = '{pattern: 2, trailer_is_sum: 1'b1, trailer: 8'h00, duty: 75,  exp_err: 1'b0};
    vecs[4] = '{pattern: 1, trailer_is_sum: 1'b0, trailer: 8'h00, duty: 100, exp_err: 1'b0};

    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready_low", 32'(bus.s_ready), 32'd0);

    for (int k = 0; k < 5; k++) full_load(vecs[k]);

    // abort at the handshake of word 0x100, plus abort-over-start in IDLE
    for (int i = 0; i < N; i++) img[i] = pat_word(0, i);
    start_load();
    for (int i = 0; i < 'h100; i++) send_word(img[i], 1'b1, AW'(i), 100);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.abort   = 1'b1;
    check("ready_at_abort", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.s_ready), 32'd0);
    check("abort_no_write", 32'(bus.wr_en), 32'd0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_beats_start", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_write_count", 32'(wr_count - wr_base), 32'h100);
    check("abort_no_done", 32'(done_count - done_base), 32'd0);
    check("abort_err_kept", 32'(bus.err), 32'd0);
    check("abort_sb_empty", 32'(sb_q.size()), 32'd0);
    full_load(vecs[0]);

    // start pulsed at word 0x050 mid-load is ignored
    for (int i = 0; i < N; i++) img[i] = pat_word(0, i);
    start_load();
    for (int i = 0; i < 'h50; i++) send_word(img[i], 1'b1, AW'(i), 100);
    bus.start = 1'b1;
    send_word(img['h50], 1'b1, AW'('h50), 100);
    bus.start = 1'b0;
    for (int i = 'h51; i < N; i++) send_word(img[i], 1'b1, AW'(i), 100);
    finish_load(8'h00, 1'b0);

    // reset asserted mid-load at word 0x200
    start_load();
    for (int i = 0; i < 'h200; i++) send_word(img[i], 1'b1, AW'(i), 100);
    bus.s_valid = 1'b1;
    bus.s_data  = img['h200];
    #2 rst_n = 1'b0;
    #1;
    check("arst_s_ready", 32'(bus.s_ready), 32'd0);
    check("arst_wr_en", 32'(bus.wr_en), 32'd0);
    check("arst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("arst_wr_data", 32'(bus.wr_data), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_ready", 32'(bus.s_ready), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_writes", 32'(wr_count - wr_base), 32'h200);
    check("post_rst_no_done", 32'(done_count - done_base), 32'd0);
    bus.s_valid = 1'b0;
    full_load(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
